mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one synchronous single-port RAM between the 65C02 core and one DMA requester.
//  - Grants each bus cycle to the CPU or the DMA.
//  - Stalls the CPU via RDY on every DMA-owned cycle.
//  - Holds the CPU's read data stable across stalls.
//  - Bounds DMA bursts so the CPU is never starved.
//  - Sits between cpu (AD/DI/DO/WE/RDY) and the RAM macro.
// PARAMETERS
//  AW         16  address width (CPU AD and dma_addr)
//  MAX_BURST  4   max consecutive DMA grants before one forced CPU cycle (1..15)
// PORTS
//  clk         in   1   system clock, rising edge
//  RST_N       in   1   asynchronous active-low reset
//  cpu_ad      in   AW  CPU address (combinational from core)
//  cpu_do      in   8   CPU write data
//  cpu_we      in   1   CPU write enable
//  cpu_lock    in   1   1 = DMA must not be granted this cycle (RMW / vector fetch)
//  cpu_di      out  8   read data to CPU DI
//  cpu_rdy     out  1   RDY to core; 0 = cycle stolen
//  dma_req     in   1   DMA access request; held with addr/we/wdata until granted
//  dma_addr    in   AW  DMA address
//  dma_we      in   1   DMA write enable
//  dma_wdata   in   8   DMA write data
//  dma_gnt     out  1   access issued this cycle (combinational)
//  dma_rdata   out  8   DMA read data
//  dma_rvalid  out  1   dma_rdata valid; 1 cycle after a granted DMA read
//  mem_addr    out  AW  RAM address
//  mem_we      out  1   RAM write enable
//  mem_wdata   out  8   RAM write data
//  mem_rdata   in   8   RAM read data; valid the cycle after mem_addr
// BEHAVIOUR
//  - Owner decision (combinational each cycle):
//    - dma_gnt = dma_req & ~cpu_lock & (state != FAIR); cpu_rdy = ~dma_gnt.
//  - Mux: mem_addr/mem_we/mem_wdata = DMA fields if dma_gnt, else CPU fields.
//    - mem_we = cpu_we & cpu_rdy in CPU cycles: a stalled CPU never writes.
//  - FSM states: CPU, DMA, FAIR; burst_cnt is 4 bits.
//    - CPU: dma_gnt -> DMA, burst_cnt = 1; otherwise stay.
//    - DMA: dma_gnt & burst_cnt == MAX_BURST-1 -> FAIR; dma_gnt -> burst_cnt+1; no grant -> CPU, cnt 0.
//    - FAIR: one cycle, always CPU-owned -> CPU, cnt 0.
//    - MAX_BURST = 1: every DMA grant is followed by FAIR.
//  - Read return: registered last_owner (1 = DMA).
//    - dma_rvalid <= dma_gnt & ~dma_we; dma_rdata = mem_rdata.
//    - cpu_di = mem_rdata when the previous cycle was CPU-owned; else hold_q.
//    - hold_q <= mem_rdata on the first stalled cycle only, so the data stays constant over any stall length.
//  - Simultaneous cpu_lock & dma_req: CPU wins; DMA waits with request held; FSM counts no grant.
//  - Reset (async, any state): state CPU, burst_cnt 0, hold_q 0x00, last_owner CPU, dma_rvalid 0.
//    - Combinational outputs follow from these values.
//    - An in-flight DMA read is dropped: no rvalid after reset.
// CONFIGURATION
//  MEM_ARB_STALL_CNT_EN defined:
//    - Adds ports stall_cnt out 16 and stall_clr in 1.
//    - Counts cycles with cpu_rdy=0, saturating at 0xFFFF.
//    - stall_clr zeroes the count and wins over an increment; reset value 0.
//  MEM_ARB_STALL_CNT_EN undefined: ports and counter are absent; behaviour otherwise identical.
// STRUCTURE
//  - Package mem_arb_pkg: FSM state encoding (ST_CPU/ST_DMA/ST_FAIR), BURST_W = 4, owner constants.
//  - Sub-module mem_arb_rdhold: last_owner + hold_q + cpu_di/dma_rdata/dma_rvalid steering.
//  - FSM, burst counter and bus mux stay in mem_arbiter.
// TESTING
//  1. No dma_req, CPU reads 0x1234 (RAM=0xA5): cpu_rdy stays 1; cpu_di=0xA5 the next cycle.
//  2. dma_req held 10 cycles, MAX_BURST=4, reads:
//     - gnt pattern 1111 0 1111 0 ...; cpu_rdy is the inverse.
//     - rvalid one cycle after each grant.
//  3. CPU reads 0x0200 (=0x3C), then 3 DMA cycles write 0x0200=0x77: cpu_di holds 0x3C through the stall.
//  4. cpu_lock=1 with dma_req=1 for 3 cycles:
//     - dma_gnt=0, mem_addr=cpu_ad; state stays CPU.
//     - Grant on the first cycle lock drops.
//  5. cpu_we=1 during a stolen cycle: mem_we follows dma_we only; RAM at cpu_ad unchanged.
//  6. RST_N low mid-burst (cnt=2) after a DMA read grant:
//     - Immediately dma_rvalid=0, state CPU.
//     - After release, the first grant starts a fresh 4-cycle burst.
//  7. (with MEM_ARB_STALL_CNT_EN) 5 stolen cycles -> stall_cnt=5; stall_clr during a stall -> 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM encoding, burst counter width and bus-owner constants for mem_arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {
        ST_CPU  = 2'd0,
        ST_DMA  = 2'd1,
        ST_FAIR = 2'd2
    } arb_state_e;
    localparam int   BURST_W = 4;
    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;
endpackage

// File: rtl/mem_arb_rdhold.sv
// mem_arb_rdhold: steers RAM read data to CPU or DMA and freezes CPU read data across stalls
module mem_arb_rdhold
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       RST_N,
    input  logic       dma_gnt_i,
    input  logic       dma_we_i,
    input  logic [7:0] mem_rdata_i,
    output logic [7:0] cpu_di_o,
    output logic [7:0] dma_rdata_o,
    output logic       dma_rvalid_o
);
    logic       last_owner_q, last_owner_d;
    logic [7:0] hold_q, hold_d;
    logic       rvalid_q, rvalid_d;

    // capture CPU read data only on the first stolen cycle, so it survives stalls of any length
    always_comb begin
        last_owner_d = dma_gnt_i ? OWN_DMA : OWN_CPU;
        hold_d       = (dma_gnt_i && last_owner_q == OWN_CPU) ? mem_rdata_i : hold_q;
        rvalid_d     = dma_gnt_i & ~dma_we_i;
    end

    // owner history, held CPU data and DMA read-valid; reset drops any in-flight DMA read
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            last_owner_q <= OWN_CPU;
            hold_q       <= 8'h00;
            rvalid_q     <= 1'b0;
        end else begin
            last_owner_q <= last_owner_d;
            hold_q       <= hold_d;
            rvalid_q     <= rvalid_d;
        end
    end

    assign cpu_di_o     = (last_owner_q == OWN_CPU) ? mem_rdata_i : hold_q;
    assign dma_rdata_o  = mem_rdata_i;
    assign dma_rvalid_o = rvalid_q;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one sync single-port RAM between the 65C02 core and a DMA requester,
// stealing cycles via RDY with bounded DMA bursts. Optional MEM_ARB_STALL_CNT_EN adds a stall counter.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW        = 16,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          RST_N,
    input  logic [AW-1:0] cpu_ad,
    input  logic [7:0]    cpu_do,
    input  logic          cpu_we,
    input  logic          cpu_lock,
    output logic [7:0]    cpu_di,
    output logic          cpu_rdy,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    input  logic          dma_we,
    input  logic [7:0]    dma_wdata,
    output logic          dma_gnt,
    output logic [7:0]    dma_rdata,
    output logic          dma_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
`ifdef MEM_ARB_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt,
    input  logic          stall_clr
`endif
);
    localparam logic [BURST_W-1:0] LAST_CNT = BURST_W'(MAX_BURST - 1);

    arb_state_e         state_q, state_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

    assign dma_gnt   = dma_req & ~cpu_lock & (state_q != ST_FAIR);
    assign cpu_rdy   = ~dma_gnt;
    assign mem_addr  = dma_gnt ? dma_addr : cpu_ad;
    assign mem_we    = dma_gnt ? dma_we : (cpu_we & cpu_rdy);
    assign mem_wdata = dma_gnt ? dma_wdata : cpu_do;

    // a grant in CPU or DMA state extends the burst; the last allowed grant forces one FAIR cycle,
    // and FAIR never grants, so it always falls back to CPU
    always_comb begin
        state_d     = dma_gnt ? ((burst_cnt_q == LAST_CNT) ? ST_FAIR : ST_DMA) : ST_CPU;
        burst_cnt_d = (dma_gnt && burst_cnt_q != LAST_CNT) ? burst_cnt_q + BURST_W'(1) : '0;
    end

    // arbitration state and burst length
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_CPU;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    mem_arb_rdhold u_rdhold (
        .clk         (clk),
        .RST_N       (RST_N),
        .dma_gnt_i   (dma_gnt),
        .dma_we_i    (dma_we),
        .mem_rdata_i (mem_rdata),
        .cpu_di_o    (cpu_di),
        .dma_rdata_o (dma_rdata),
        .dma_rvalid_o(dma_rvalid)
    );

`ifdef MEM_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // saturating count of stolen CPU cycles; clear beats increment
    always_comb begin
        stall_cnt_d = stall_clr ? 16'h0000 :
                      (!cpu_rdy && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end

    // stall counter register
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) stall_cnt_q <= 16'h0000;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed + random checks of mem_arbiter against a burst-counting reference model
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] cpu_ad, dma_addr, mem_addr;
    logic [7:0]    cpu_do, cpu_di, dma_wdata, dma_rdata, mem_wdata, mem_rdata;
    logic          cpu_we, cpu_lock, cpu_rdy, dma_req, dma_we, dma_gnt, dma_rvalid, mem_we;
`ifdef MEM_ARB_STALL_CNT_EN
    logic [15:0]   stall_cnt;
    logic          stall_clr;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .MAX_BURST(MB)) dut (
        .clk(clk), .RST_N(rst_n),
        .cpu_ad(cpu_ad), .cpu_do(cpu_do), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
        .cpu_di(cpu_di), .cpu_rdy(cpu_rdy),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STALL_CNT_EN
        , .stall_cnt(stall_cnt), .stall_clr(stall_clr)
`endif
    );

    // RAM macro: synchronous, read-first
    logic [7:0] ram [0:65535];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // reference model state
    logic [7:0] ref_ram [0:65535];
    int         n_cmp = 0, n_fail = 0;
    int         m_run, m_stall;
    bit         m_fair, m_rv, m_di_ok, exp_gnt;
    logic [7:0] m_rdata, m_di;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_fair = 0; m_rv = 0; m_di_ok = 0; m_stall = 0;
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] v);
        ram[a] = v;
        ref_ram[a] = v;
    endtask

    // one bus cycle: check owner/mux, clock, advance model, check read return
    task automatic cyc();
        #1;
        exp_gnt = dma_req && !cpu_lock && !m_fair;
        check("gnt", dma_gnt, exp_gnt);
        check("rdy", cpu_rdy, !exp_gnt);
        check("mem_addr", mem_addr, exp_gnt ? dma_addr : cpu_ad);
        check("mem_we", mem_we, exp_gnt ? dma_we : cpu_we);
        if (exp_gnt ? dma_we : cpu_we) check("mem_wdata", mem_wdata, exp_gnt ? dma_wdata : cpu_do);
        @(posedge clk);
        if (exp_gnt) begin
            m_rv = !dma_we;
            m_rdata = ref_ram[dma_addr];
            if (dma_we) ref_ram[dma_addr] = dma_wdata;
        end else begin
            m_rv = 0;
            m_di = ref_ram[cpu_ad];
            m_di_ok = 1;
            if (cpu_we) ref_ram[cpu_ad] = cpu_do;
        end
`ifdef MEM_ARB_STALL_CNT_EN
        if (stall_clr) m_stall = 0;
        else if (exp_gnt && m_stall < 65535) m_stall++;
`endif
        if (m_fair) begin
            m_fair = 0; m_run = 0;
        end else if (exp_gnt) begin
            m_run++;
            if (m_run == MB) begin m_fair = 1; m_run = 0; end
        end else m_run = 0;
        #1;
        check("rvalid", dma_rvalid, m_rv);
        if (m_rv) check("rdata", dma_rdata, m_rdata);
        if (m_di_ok) check("cpu_di", cpu_di, m_di);
`ifdef MEM_ARB_STALL_CNT_EN
        check("stall_cnt", stall_cnt, m_stall);
`endif
    endtask

    initial begin
        logic [9:0] pat;
        for (int i = 0; i < 65536; i++) begin ram[i] = 8'h00; ref_ram[i] = 8'h00; end
        rst_n = 0; cpu_ad = 16'h00AA; cpu_do = 0; cpu_we = 0; cpu_lock = 0;
        dma_req = 0; dma_addr = 0; dma_we = 0; dma_wdata = 0;
`ifdef MEM_ARB_STALL_CNT_EN
        stall_clr = 0;
`endif
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_rvalid", dma_rvalid, 1'b0);
        check("rst_rdy", cpu_rdy, 1'b1);
        check("rst_addr", mem_addr, 16'h00AA);
        check("rst_we", mem_we, 1'b0);
`ifdef MEM_ARB_STALL_CNT_EN
        check("rst_stall", stall_cnt, 16'h0000);
`endif
        rst_n = 1;

        // 1: plain CPU read
        poke(16'h1234, 8'hA5);
        cpu_ad = 16'h1234;
        cyc();
        check("t1_di", cpu_di, 8'hA5);
        check("t1_rdy", cpu_rdy, 1'b1);

        // 2: held DMA reads, burst of 4 then one forced CPU cycle
        pat = 10'b1111011110;
        poke(16'h4000, 8'h5A);
        dma_req = 1; dma_addr = 16'h4000; dma_we = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("t2_gnt", dma_gnt, pat[9-i]);
            check("t2_rdy", cpu_rdy, !pat[9-i]);
            cyc();
            check("t2_rvalid", dma_rvalid, pat[9-i]);
        end
        dma_req = 0;
        cyc();

        // 3: CPU read data held through a 3-cycle DMA write stall
        poke(16'h0200, 8'h3C);
        cpu_ad = 16'h0200;
        cyc();
        dma_req = 1; dma_addr = 16'h0200; dma_we = 1; dma_wdata = 8'h77;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t3_hold", cpu_di, 8'h3C);
        end
        dma_req = 0; dma_we = 0;
        cyc();
        cyc();
        check("t3_new", cpu_di, 8'h77);

        // 4: lock blocks the DMA, grant on first unlocked cycle
        cpu_lock = 1; cpu_ad = 16'h0123;
        dma_req = 1; dma_addr = 16'h0400; dma_we = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_gnt", dma_gnt, 1'b0);
            check("t4_addr", mem_addr, 16'h0123);
            cyc();
        end
        cpu_lock = 0;
        #1;
        check("t4_gnt_drop", dma_gnt, 1'b1);
        cyc();
        dma_req = 0;
        cyc();

        // 5: stalled CPU write must not reach RAM
        poke(16'h0300, 8'h11);
        cpu_ad = 16'h0300; cpu_we = 1; cpu_do = 8'hEE;
        dma_req = 1; dma_addr = 16'h0310; dma_we = 1; dma_wdata = 8'h55;
        #1;
        check("t5_we_w", mem_we, 1'b1);
        cyc();
        dma_we = 0;
        #1;
        check("t5_we_r", mem_we, 1'b0);
        cyc();
        check("t5_ram", ram[16'h0300], 8'h11);
        check("t5_dma", ram[16'h0310], 8'h55);
        cpu_we = 0; dma_req = 0;
        cyc();

        // 6: reset mid-burst after a DMA read grant
        dma_req = 1; dma_addr = 16'h4000; dma_we = 0;
        cyc();
        cyc();
        check("t6_pre_rv", dma_rvalid, 1'b1);
        rst_n = 0;
        #1;
        check("t6_rv", dma_rvalid, 1'b0);
        check("t6_gnt", dma_gnt, 1'b1);
        rst_n = 1;
        model_reset();
        pat = 10'b1111011110;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t6_burst", dma_gnt, pat[9-i]);
            cyc();
        end
        dma_req = 0;
        cyc();

`ifdef MEM_ARB_STALL_CNT_EN
        // 7: stall counter counts stolen cycles and clears during a stall
        stall_clr = 1;
        cyc();
        stall_clr = 0;
        dma_req = 1;
        for (int i = 0; i < 6; i++) cyc();
        check("t7_cnt", stall_cnt, 16'd5);
        stall_clr = 1;
        cyc();
        check("t7_clr", stall_cnt, 16'd0);
        stall_clr = 0; dma_req = 0;
        cyc();
`endif

        // random traffic; DMA holds its request fields until granted
        for (int i = 0; i < 400; i++) begin
            if (!dma_req || exp_gnt) begin
                dma_req   = ($urandom_range(0, 2) != 0);
                dma_addr  = 16'($urandom_range(0, 15));
                dma_we    = ($urandom_range(0, 2) == 0);
                dma_wdata = 8'($urandom);
            end
            cpu_ad   = 16'($urandom_range(0, 15));
            cpu_we   = ($urandom_range(0, 3) == 0);
            cpu_do   = 8'($urandom);
            cpu_lock = ($urandom_range(0, 4) == 0);
`ifdef MEM_ARB_STALL_CNT_EN
            stall_clr = ($urandom_range(0, 30) == 0);
`endif
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
